// File: rtl/fir_output_stage.sv
// Output stage for the FIR DSP chain: it rounds the 48-bit accumulator, shifts it
// arithmetically and saturates it to OUT_BITS, then buffers samples in an FWFT FIFO.
module fir_output_stage #(
  parameter int    OUT_BITS   = 16,
  parameter int    FRAC_SHIFT = 14,
  parameter string ROUND_MODE = "HALF_UP",
  parameter int    FIFO_DEPTH = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [47:0]         p_i,
  input  logic                p_valid_i,
  input  logic                clr_i,
  output logic [OUT_BITS-1:0] m_tdata_o,
  output logic                m_tvalid_o,
  input  logic                m_tready_i,
  output logic                sat_o,
  output logic [15:0]         sat_count_o,
  output logic [15:0]         drop_count_o
);

  localparam int STAGES = 2;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int RC_SH  = (FRAC_SHIFT > 0) ? FRAC_SHIFT - 1 : 0;
  localparam logic signed [48:0] RC =
    (ROUND_MODE == "HALF_UP" && FRAC_SHIFT > 0) ? (49'sd1 <<< RC_SH) : 49'sd0;
  localparam logic signed [48:0] MAX_V = (49'sd1 <<< (OUT_BITS - 1)) - 49'sd1;
  localparam logic signed [48:0] MIN_V = -(49'sd1 <<< (OUT_BITS - 1));

  typedef struct packed {
    logic                sat;
    logic [OUT_BITS-1:0] data;
  } samp_t;

  logic [STAGES:1]    vld_pipe;
  logic signed [48:0] r_q;
  logic signed [48:0] shifted;
  samp_t              s2_d, s2_q;

  always_comb begin
    shifted   = r_q >>> FRAC_SHIFT;
    s2_d.sat  = 1'b0;
    s2_d.data = shifted[OUT_BITS-1:0];
    if (shifted > MAX_V) begin
      s2_d.sat  = 1'b1;
      s2_d.data = MAX_V[OUT_BITS-1:0];
    end else if (shifted < MIN_V) begin
      s2_d.sat  = 1'b1;
      s2_d.data = MIN_V[OUT_BITS-1:0];
    end
  end

  // The 49-bit sum leaves headroom for the rounding constant, so it cannot wrap.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_pipe <= '0;
      r_q      <= '0;
      s2_q     <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], p_valid_i};
      r_q      <= $signed({p_i[47], p_i}) + RC;
      s2_q     <= s2_d;
    end
  end

  // The extra pointer MSB distinguishes a full FIFO from an empty one.
  logic [OUT_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW:0]         wr_ptr, rd_ptr;
  logic                full, rd_en, wr_en, drop_ev, sat_ev;

  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign m_tvalid_o = (wr_ptr != rd_ptr);
  assign m_tdata_o  = mem[rd_ptr[AW-1:0]];
  assign rd_en      = m_tvalid_o && m_tready_i;
  assign wr_en      = vld_pipe[STAGES] && (!full || rd_en);
  assign drop_ev    = vld_pipe[STAGES] && full && !rd_en;
  assign sat_ev     = vld_pipe[STAGES] && s2_q.sat;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr[AW-1:0]] <= s2_q.data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // A clear in the same cycle as an event wins, and the event is lost.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      sat_o        <= 1'b0;
      sat_count_o  <= '0;
      drop_count_o <= '0;
    end else begin
      if (sat_ev) begin
        sat_o <= 1'b1;
        if (sat_count_o != 16'hFFFF) sat_count_o <= sat_count_o + 16'd1;
      end
      if (drop_ev && drop_count_o != 16'hFFFF) drop_count_o <= drop_count_o + 16'd1;
    end
  end

endmodule

// File: tb/tb_fir_output_stage.sv
// Self-checking bench for fir_output_stage: it uses vector tables, directed corner
// cases and random traffic, all compared against a cycle-level queue model.
module tb_fir_output_stage;

  localparam int OB = 16, FS = 14, DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0, clr = 1'b0, p_valid = 1'b0, tready = 1'b0;
  logic [47:0] p_in = '0;
  logic [15:0] tdata, sat_cnt, drop_cnt;
  logic        tvalid, sat;

  logic        pv8 = 1'b0, clr8 = 1'b0, rdy8 = 1'b1;
  logic [47:0] p8 = '0;
  logic [7:0]  tdata8;
  logic        tvalid8, sat8;
  logic [15:0] sat_cnt8, drop_cnt8;

  always #5 clk = ~clk;

  fir_output_stage dut (
    .clk_i(clk), .rst_i(rst), .p_i(p_in), .p_valid_i(p_valid), .clr_i(clr),
    .m_tdata_o(tdata), .m_tvalid_o(tvalid), .m_tready_i(tready),
    .sat_o(sat), .sat_count_o(sat_cnt), .drop_count_o(drop_cnt)
  );

  fir_output_stage #(.OUT_BITS(8), .FRAC_SHIFT(0), .ROUND_MODE("TRUNCATE"), .FIFO_DEPTH(4)) dut8 (
    .clk_i(clk), .rst_i(rst), .p_i(p8), .p_valid_i(pv8), .clr_i(clr8),
    .m_tdata_o(tdata8), .m_tvalid_o(tvalid8), .m_tready_i(rdy8),
    .sat_o(sat8), .sat_count_o(sat_cnt8), .drop_count_o(drop_cnt8)
  );

  int nvec = 0, nerr = 0;

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: plain arithmetic for the sample value, and queues for the pipe and FIFO.
  longint q[$];
  bit     m1_v, m2_v, m1_s, m2_s, msat;
  longint m1_d, m2_d;
  int     msat_cnt, mdrop_cnt;

  function automatic void ref_calc(input longint p, output longint v, output bit s);
    longint r, lim_hi, lim_lo;
    lim_hi = (longint'(1) <<< (OB - 1)) - 1;
    lim_lo = -(longint'(1) <<< (OB - 1));
    r = p + ((FS > 0) ? (longint'(1) <<< (FS - 1)) : 0);
    r = r >>> FS;
    s = 1'b0;
    v = r;
    if (r > lim_hi) begin v = lim_hi; s = 1'b1; end
    if (r < lim_lo) begin v = lim_lo; s = 1'b1; end
  endfunction

  task automatic model_update(input bit pv, input longint pp, input bit rdy, input bit cl, input bit rs);
    bit rd, drop;
    if (rs) begin
      q.delete();
      m1_v = 0; m2_v = 0; msat = 0; msat_cnt = 0; mdrop_cnt = 0;
      return;
    end
    rd = (q.size() > 0) && rdy;
    drop = 0;
    if (rd) void'(q.pop_front());
    if (m2_v) begin
      if (q.size() < DEPTH) q.push_back(m2_d);
      else drop = 1;
    end
    if (cl) begin
      msat = 0; msat_cnt = 0; mdrop_cnt = 0;
    end else begin
      if (m2_v && m2_s) begin
        msat = 1;
        if (msat_cnt < 65535) msat_cnt++;
      end
      if (drop && mdrop_cnt < 65535) mdrop_cnt++;
    end
    m2_v = m1_v; m2_d = m1_d; m2_s = m1_s;
    m1_v = pv;
    ref_calc(pp, m1_d, m1_s);
  endtask

  task automatic model_check();
    chk("tvalid", 64'(tvalid), 64'(q.size() > 0));
    if (q.size() > 0) chk("tdata", 64'($signed(tdata)), q[0]);
    chk("sat_o", 64'(sat), 64'(msat));
    chk("sat_count", 64'(sat_cnt), 64'(msat_cnt));
    chk("drop_count", 64'(drop_cnt), 64'(mdrop_cnt));
  endtask

  task automatic step(input bit pv, input longint pp, input bit rdy, input bit cl, input bit rs);
    p_valid = pv; p_in = pp[47:0]; tready = rdy; clr = cl; rst = rs;
    @(posedge clk);
    model_update(pv, pp, rdy, cl, rs);
    @(negedge clk);
    model_check();
  endtask

  typedef struct { longint p; longint exp; int sat_cnt; } vec_t;
  vec_t tbl[10];

  initial begin
    longint rp;
    tbl[0] = '{48'sh2000, 1, 0};
    tbl[1] = '{48'sh1FFF, 0, 0};
    tbl[2] = '{-64'sh2000, 0, 0};
    tbl[3] = '{48'sh5FFF, 1, 0};
    tbl[4] = '{longint'(1) <<< 30, 32767, 1};
    tbl[5] = '{-(longint'(1) <<< 31), -32768, 2};
    tbl[6] = '{longint'(32767) * 16384, 32767, 2};
    tbl[7] = '{longint'(32767) * 16384 + 8192, 32767, 3};
    tbl[8] = '{longint'(-32768) * 16384, -32768, 3};
    tbl[9] = '{longint'(-32768) * 16384 - 8193, -32768, 4};

    @(negedge clk);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("rst_tvalid", 64'(tvalid), 0);
    chk("rst_tdata", 64'(tdata), 0);
    chk("rst_tvalid8", 64'(tvalid8), 0);

    // Narrow, truncating instance with no fractional shift
    pv8 = 1; p8 = 48'd127;   step(0, 0, 0, 0, 0);
    p8 = 48'd128;            step(0, 0, 0, 0, 0);
    p8 = -48'sd129;          step(0, 0, 0, 0, 0);
    pv8 = 0;
    chk("t8_v0", 64'(tvalid8), 1);
    chk("t8_d0", 64'($signed(tdata8)), 127);
    step(0, 0, 0, 0, 0);
    chk("t8_d1", 64'($signed(tdata8)), 127);
    step(0, 0, 0, 0, 0);
    chk("t8_d2", 64'($signed(tdata8)), -128);
    chk("t8_satcnt", 64'(sat_cnt8), 2);

    // Single-sample vectors: each one must appear exactly 3 cycles after entry
    foreach (tbl[i]) begin
      step(1, tbl[i].p, 1, 0, 0);
      step(0, 0, 1, 0, 0);
      chk("lat_early", 64'(tvalid), 0);
      step(0, 0, 1, 0, 0);
      chk("vec_valid", 64'(tvalid), 1);
      chk("vec_data", 64'($signed(tdata)), tbl[i].exp);
      chk("vec_satcnt", 64'(sat_cnt), 64'(tbl[i].sat_cnt));
      step(0, 0, 1, 0, 0);
    end

    step(0, 0, 1, 1, 0);
    chk("clr_sat", 64'(sat), 0);
    chk("clr_cnt", 64'(sat_cnt), 0);

    // Back-to-back rounding stream
    step(1, 48'sh2000, 1, 0, 0);
    step(1, 48'sh1FFF, 1, 0, 0);
    step(1, -64'sh2000, 1, 0, 0);
    step(1, 48'sh5FFF, 1, 0, 0);
    repeat (5) step(0, 0, 1, 0, 0);

    // Backpressure: six samples into a four-entry FIFO
    for (int k = 1; k <= 6; k++) step(1, longint'(k) <<< 14, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0, 0);
    chk("bp_drop", 64'(drop_cnt), 2);
    chk("bp_valid", 64'(tvalid), 1);
    for (int k = 1; k <= 4; k++) begin
      chk("bp_order", 64'($signed(tdata)), k);
      step(0, 0, 1, 0, 0);
    end
    chk("bp_empty", 64'(tvalid), 0);

    // Full FIFO: a write that lands on a handshake edge must not be dropped
    for (int k = 10; k <= 13; k++) step(1, longint'(k) <<< 14, 0, 0, 0);
    step(1, longint'(14) <<< 14, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("fr_nodrop", 64'(drop_cnt), 2);
    for (int k = 11; k <= 14; k++) begin
      chk("fr_order", 64'($signed(tdata)), k);
      step(0, 0, 1, 0, 0);
    end

    // Reset with three samples buffered and two in flight
    for (int k = 20; k <= 24; k++) step(1, longint'(k) <<< 14, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    chk("mr_valid", 64'(tvalid), 0);
    chk("mr_drop", 64'(drop_cnt), 0);
    chk("mr_sat", 64'(sat_cnt), 0);
    for (int k = 0; k < 10; k++) begin
      step(0, 0, 1, 0, 0);
      chk("mr_stale", 64'(tvalid), 0);
    end

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(1) == 1) rp = longint'($signed($urandom));
      else rp = longint'($signed($urandom)) >>> 2;
      step($urandom_range(9) < 7, rp, $urandom_range(1) == 1,
           $urandom_range(99) < 3, $urandom_range(199) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
